// File: rtl/e603_subsys_axi_ost_limiter.sv
// e603_subsys_axi_ost_limiter
// Caps the number of outstanding AXI4 read and write bursts heading to the
// async bridge. All payloads and the W/R/B channels pass straight through;
// only AR and AW valid/ready are gated. The gates look only at the registered
// counts, so a slot freed by a response in cycle N can be reused in cycle N+1.
// Optional feature: define E603_AXI_OST_ERR_EN to get a sticky ost_err flag
// that sets on any response arriving with a zero count (underflow).
//
// Handshake semantics: a transfer happens on a cycle where valid and ready
// are both high at the rising edge of clk. Valid never depends on ready here,
// except that both are forced low together while the channel is full.
module e603_subsys_axi_ost_limiter #(
  parameter int AW     = 32,
  parameter int DW     = 32,
  parameter int ID_W   = 4,
  parameter int USR_W  = 4,
  parameter int MW     = 4,
  parameter int RD_OST = 4,
  parameter int WR_OST = 4
) (
  input  logic              clk,
  input  logic              rst,
  // upstream AR
  input  logic [AW-1:0]     i_axi_araddr,
  input  logic [ID_W-1:0]   i_axi_arid,
  input  logic [7:0]        i_axi_arlen,
  input  logic [2:0]        i_axi_arsize,
  input  logic [1:0]        i_axi_arburst,
  input  logic              i_axi_arlock,
  input  logic [3:0]        i_axi_arcache,
  input  logic [2:0]        i_axi_arprot,
  input  logic [3:0]        i_axi_arqos,
  input  logic [USR_W-1:0]  i_axi_aruser,
  input  logic              i_axi_arvalid,
  output logic              i_axi_arready,
  // upstream AW
  input  logic [AW-1:0]     i_axi_awaddr,
  input  logic [ID_W-1:0]   i_axi_awid,
  input  logic [7:0]        i_axi_awlen,
  input  logic [2:0]        i_axi_awsize,
  input  logic [1:0]        i_axi_awburst,
  input  logic              i_axi_awlock,
  input  logic [3:0]        i_axi_awcache,
  input  logic [2:0]        i_axi_awprot,
  input  logic [3:0]        i_axi_awqos,
  input  logic [USR_W-1:0]  i_axi_awuser,
  input  logic              i_axi_awvalid,
  output logic              i_axi_awready,
  // upstream W
  input  logic [DW-1:0]     i_axi_wdata,
  input  logic [MW-1:0]     i_axi_wstrb,
  input  logic              i_axi_wlast,
  input  logic [USR_W-1:0]  i_axi_wuser,
  input  logic              i_axi_wvalid,
  output logic              i_axi_wready,
  // downstream AR
  output logic [AW-1:0]     o_axi_araddr,
  output logic [ID_W-1:0]   o_axi_arid,
  output logic [7:0]        o_axi_arlen,
  output logic [2:0]        o_axi_arsize,
  output logic [1:0]        o_axi_arburst,
  output logic              o_axi_arlock,
  output logic [3:0]        o_axi_arcache,
  output logic [2:0]        o_axi_arprot,
  output logic [3:0]        o_axi_arqos,
  output logic [USR_W-1:0]  o_axi_aruser,
  output logic              o_axi_arvalid,
  input  logic              o_axi_arready,
  // downstream AW
  output logic [AW-1:0]     o_axi_awaddr,
  output logic [ID_W-1:0]   o_axi_awid,
  output logic [7:0]        o_axi_awlen,
  output logic [2:0]        o_axi_awsize,
  output logic [1:0]        o_axi_awburst,
  output logic              o_axi_awlock,
  output logic [3:0]        o_axi_awcache,
  output logic [2:0]        o_axi_awprot,
  output logic [3:0]        o_axi_awqos,
  output logic [USR_W-1:0]  o_axi_awuser,
  output logic              o_axi_awvalid,
  input  logic              o_axi_awready,
  // downstream W
  output logic [DW-1:0]     o_axi_wdata,
  output logic [MW-1:0]     o_axi_wstrb,
  output logic              o_axi_wlast,
  output logic [USR_W-1:0]  o_axi_wuser,
  output logic              o_axi_wvalid,
  input  logic              o_axi_wready,
  // downstream R/B (responses from the bridge)
  input  logic [ID_W-1:0]   o_axi_rid,
  input  logic [DW-1:0]     o_axi_rdata,
  input  logic [1:0]        o_axi_rresp,
  input  logic              o_axi_rlast,
  input  logic [USR_W-1:0]  o_axi_ruser,
  input  logic              o_axi_rvalid,
  output logic              o_axi_rready,
  input  logic [ID_W-1:0]   o_axi_bid,
  input  logic [1:0]        o_axi_bresp,
  input  logic [USR_W-1:0]  o_axi_buser,
  input  logic              o_axi_bvalid,
  output logic              o_axi_bready,
  // upstream R/B
  output logic [ID_W-1:0]   i_axi_rid,
  output logic [DW-1:0]     i_axi_rdata,
  output logic [1:0]        i_axi_rresp,
  output logic              i_axi_rlast,
  output logic [USR_W-1:0]  i_axi_ruser,
  output logic              i_axi_rvalid,
  input  logic              i_axi_rready,
  output logic [ID_W-1:0]   i_axi_bid,
  output logic [1:0]        i_axi_bresp,
  output logic [USR_W-1:0]  i_axi_buser,
  output logic              i_axi_bvalid,
  input  logic              i_axi_bready,
  // status
  output logic [7:0]        rd_ost_cnt,
  output logic [7:0]        wr_ost_cnt,
  output logic              idle,
  output logic              ost_err
);

  localparam logic [7:0] RD_MAX = 8'(RD_OST);
  localparam logic [7:0] WR_MAX = 8'(WR_OST);

  logic rd_full, wr_full;
  logic rd_inc, rd_dec, wr_inc, wr_dec;

  // Payload and W/R/B pass-through: pure wires, no reset, no latency.
  assign o_axi_araddr  = i_axi_araddr;
  assign o_axi_arid    = i_axi_arid;
  assign o_axi_arlen   = i_axi_arlen;
  assign o_axi_arsize  = i_axi_arsize;
  assign o_axi_arburst = i_axi_arburst;
  assign o_axi_arlock  = i_axi_arlock;
  assign o_axi_arcache = i_axi_arcache;
  assign o_axi_arprot  = i_axi_arprot;
  assign o_axi_arqos   = i_axi_arqos;
  assign o_axi_aruser  = i_axi_aruser;
  assign o_axi_awaddr  = i_axi_awaddr;
  assign o_axi_awid    = i_axi_awid;
  assign o_axi_awlen   = i_axi_awlen;
  assign o_axi_awsize  = i_axi_awsize;
  assign o_axi_awburst = i_axi_awburst;
  assign o_axi_awlock  = i_axi_awlock;
  assign o_axi_awcache = i_axi_awcache;
  assign o_axi_awprot  = i_axi_awprot;
  assign o_axi_awqos   = i_axi_awqos;
  assign o_axi_awuser  = i_axi_awuser;
  assign o_axi_wdata   = i_axi_wdata;
  assign o_axi_wstrb   = i_axi_wstrb;
  assign o_axi_wlast   = i_axi_wlast;
  assign o_axi_wuser   = i_axi_wuser;
  assign o_axi_wvalid  = i_axi_wvalid;
  assign i_axi_wready  = o_axi_wready;
  assign i_axi_rid     = o_axi_rid;
  assign i_axi_rdata   = o_axi_rdata;
  assign i_axi_rresp   = o_axi_rresp;
  assign i_axi_rlast   = o_axi_rlast;
  assign i_axi_ruser   = o_axi_ruser;
  assign i_axi_rvalid  = o_axi_rvalid;
  assign o_axi_rready  = i_axi_rready;
  assign i_axi_bid     = o_axi_bid;
  assign i_axi_bresp   = o_axi_bresp;
  assign i_axi_buser   = o_axi_buser;
  assign i_axi_bvalid  = o_axi_bvalid;
  assign o_axi_bready  = i_axi_bready;

  // Gates are driven from registered counts only (no path from R/B).
  assign rd_full       = (rd_ost_cnt == RD_MAX);
  assign wr_full       = (wr_ost_cnt == WR_MAX);
  assign o_axi_arvalid = i_axi_arvalid & ~rd_full;
  assign i_axi_arready = o_axi_arready & ~rd_full;
  assign o_axi_awvalid = i_axi_awvalid & ~wr_full;
  assign i_axi_awready = o_axi_awready & ~wr_full;

  assign rd_inc = o_axi_arvalid & o_axi_arready;
  assign rd_dec = i_axi_rvalid & i_axi_rready & i_axi_rlast;
  assign wr_inc = o_axi_awvalid & o_axi_awready;
  assign wr_dec = i_axi_bvalid & i_axi_bready;

  assign idle = (rd_ost_cnt == 8'd0) & (wr_ost_cnt == 8'd0);

  // Read outstanding counter: +1 on AR, -1 on rlast, saturates at 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ost_cnt <= 8'd0;
    end else if (rd_inc && !rd_dec) begin
      rd_ost_cnt <= rd_ost_cnt + 8'd1;
    end else if (rd_dec && !rd_inc && rd_ost_cnt != 8'd0) begin
      rd_ost_cnt <= rd_ost_cnt - 8'd1;
    end
  end

  // Write outstanding counter: +1 on AW, -1 on B, saturates at 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ost_cnt <= 8'd0;
    end else if (wr_inc && !wr_dec) begin
      wr_ost_cnt <= wr_ost_cnt + 8'd1;
    end else if (wr_dec && !wr_inc && wr_ost_cnt != 8'd0) begin
      wr_ost_cnt <= wr_ost_cnt - 8'd1;
    end
  end

`ifdef E603_AXI_OST_ERR_EN
  // A lone response with nothing outstanding is an underflow. A response
  // that coincides with a new request leaves the count alone and is not one.
  logic rd_unf, wr_unf;
  assign rd_unf = rd_dec & ~rd_inc & (rd_ost_cnt == 8'd0);
  assign wr_unf = wr_dec & ~wr_inc & (wr_ost_cnt == 8'd0);

  // Sticky underflow flag, cleared only by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      ost_err <= 1'b0;
    end else if (rd_unf || wr_unf) begin
      ost_err <= 1'b1;
    end
  end
`else
  assign ost_err = 1'b0;
`endif

endmodule

// File: tb/tb_e603_subsys_axi_ost_limiter.sv
// Bench for e603_subsys_axi_ost_limiter (RD_OST=2, WR_OST=1). Directed
// scenarios followed by a randomized run, all checked against a queue-based
// model of outstanding bursts. Honours E603_AXI_OST_ERR_EN for ost_err.
module tb_e603_subsys_axi_ost_limiter;
  localparam int AW = 32, DW = 32, ID_W = 4, USR_W = 4, MW = 4;
  localparam int RD_OST = 2, WR_OST = 1;

  logic clk = 1'b0, rst = 1'b0;
  logic [AW-1:0] i_axi_araddr, i_axi_awaddr, o_axi_araddr, o_axi_awaddr;
  logic [ID_W-1:0] i_axi_arid, i_axi_awid, o_axi_arid, o_axi_awid;
  logic [7:0] i_axi_arlen, i_axi_awlen, o_axi_arlen, o_axi_awlen;
  logic [2:0] i_axi_arsize, i_axi_awsize, o_axi_arsize, o_axi_awsize;
  logic [1:0] i_axi_arburst, i_axi_awburst, o_axi_arburst, o_axi_awburst;
  logic i_axi_arlock, i_axi_awlock, o_axi_arlock, o_axi_awlock;
  logic [3:0] i_axi_arcache, i_axi_awcache, o_axi_arcache, o_axi_awcache;
  logic [2:0] i_axi_arprot, i_axi_awprot, o_axi_arprot, o_axi_awprot;
  logic [3:0] i_axi_arqos, i_axi_awqos, o_axi_arqos, o_axi_awqos;
  logic [USR_W-1:0] i_axi_aruser, i_axi_awuser, o_axi_aruser, o_axi_awuser;
  logic i_axi_arvalid, i_axi_arready, o_axi_arvalid, o_axi_arready;
  logic i_axi_awvalid, i_axi_awready, o_axi_awvalid, o_axi_awready;
  logic [DW-1:0] i_axi_wdata, o_axi_wdata;
  logic [MW-1:0] i_axi_wstrb, o_axi_wstrb;
  logic i_axi_wlast, o_axi_wlast;
  logic [USR_W-1:0] i_axi_wuser, o_axi_wuser;
  logic i_axi_wvalid, i_axi_wready, o_axi_wvalid, o_axi_wready;
  logic [ID_W-1:0] o_axi_rid, i_axi_rid, o_axi_bid, i_axi_bid;
  logic [DW-1:0] o_axi_rdata, i_axi_rdata;
  logic [1:0] o_axi_rresp, i_axi_rresp, o_axi_bresp, i_axi_bresp;
  logic o_axi_rlast, i_axi_rlast;
  logic [USR_W-1:0] o_axi_ruser, i_axi_ruser, o_axi_buser, i_axi_buser;
  logic o_axi_rvalid, o_axi_rready, i_axi_rvalid, i_axi_rready;
  logic o_axi_bvalid, o_axi_bready, i_axi_bvalid, i_axi_bready;
  logic [7:0] rd_ost_cnt, wr_ost_cnt;
  logic idle, ost_err;

  e603_subsys_axi_ost_limiter #(.AW(AW), .DW(DW), .ID_W(ID_W), .USR_W(USR_W),
    .MW(MW), .RD_OST(RD_OST), .WR_OST(WR_OST)) dut (
    .clk(clk), .rst(rst),
    .i_axi_araddr(i_axi_araddr), .i_axi_arid(i_axi_arid), .i_axi_arlen(i_axi_arlen),
    .i_axi_arsize(i_axi_arsize), .i_axi_arburst(i_axi_arburst), .i_axi_arlock(i_axi_arlock),
    .i_axi_arcache(i_axi_arcache), .i_axi_arprot(i_axi_arprot), .i_axi_arqos(i_axi_arqos),
    .i_axi_aruser(i_axi_aruser), .i_axi_arvalid(i_axi_arvalid), .i_axi_arready(i_axi_arready),
    .i_axi_awaddr(i_axi_awaddr), .i_axi_awid(i_axi_awid), .i_axi_awlen(i_axi_awlen),
    .i_axi_awsize(i_axi_awsize), .i_axi_awburst(i_axi_awburst), .i_axi_awlock(i_axi_awlock),
    .i_axi_awcache(i_axi_awcache), .i_axi_awprot(i_axi_awprot), .i_axi_awqos(i_axi_awqos),
    .i_axi_awuser(i_axi_awuser), .i_axi_awvalid(i_axi_awvalid), .i_axi_awready(i_axi_awready),
    .i_axi_wdata(i_axi_wdata), .i_axi_wstrb(i_axi_wstrb), .i_axi_wlast(i_axi_wlast),
    .i_axi_wuser(i_axi_wuser), .i_axi_wvalid(i_axi_wvalid), .i_axi_wready(i_axi_wready),
    .o_axi_araddr(o_axi_araddr), .o_axi_arid(o_axi_arid), .o_axi_arlen(o_axi_arlen),
    .o_axi_arsize(o_axi_arsize), .o_axi_arburst(o_axi_arburst), .o_axi_arlock(o_axi_arlock),
    .o_axi_arcache(o_axi_arcache), .o_axi_arprot(o_axi_arprot), .o_axi_arqos(o_axi_arqos),
    .o_axi_aruser(o_axi_aruser), .o_axi_arvalid(o_axi_arvalid), .o_axi_arready(o_axi_arready),
    .o_axi_awaddr(o_axi_awaddr), .o_axi_awid(o_axi_awid), .o_axi_awlen(o_axi_awlen),
    .o_axi_awsize(o_axi_awsize), .o_axi_awburst(o_axi_awburst), .o_axi_awlock(o_axi_awlock),
    .o_axi_awcache(o_axi_awcache), .o_axi_awprot(o_axi_awprot), .o_axi_awqos(o_axi_awqos),
    .o_axi_awuser(o_axi_awuser), .o_axi_awvalid(o_axi_awvalid), .o_axi_awready(o_axi_awready),
    .o_axi_wdata(o_axi_wdata), .o_axi_wstrb(o_axi_wstrb), .o_axi_wlast(o_axi_wlast),
    .o_axi_wuser(o_axi_wuser), .o_axi_wvalid(o_axi_wvalid), .o_axi_wready(o_axi_wready),
    .o_axi_rid(o_axi_rid), .o_axi_rdata(o_axi_rdata), .o_axi_rresp(o_axi_rresp),
    .o_axi_rlast(o_axi_rlast), .o_axi_ruser(o_axi_ruser), .o_axi_rvalid(o_axi_rvalid),
    .o_axi_rready(o_axi_rready), .o_axi_bid(o_axi_bid), .o_axi_bresp(o_axi_bresp),
    .o_axi_buser(o_axi_buser), .o_axi_bvalid(o_axi_bvalid), .o_axi_bready(o_axi_bready),
    .i_axi_rid(i_axi_rid), .i_axi_rdata(i_axi_rdata), .i_axi_rresp(i_axi_rresp),
    .i_axi_rlast(i_axi_rlast), .i_axi_ruser(i_axi_ruser), .i_axi_rvalid(i_axi_rvalid),
    .i_axi_rready(i_axi_rready), .i_axi_bid(i_axi_bid), .i_axi_bresp(i_axi_bresp),
    .i_axi_buser(i_axi_buser), .i_axi_bvalid(i_axi_bvalid), .i_axi_bready(i_axi_bready),
    .rd_ost_cnt(rd_ost_cnt), .wr_ost_cnt(wr_ost_cnt), .idle(idle), .ost_err(ost_err)
  );

  // Clock
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: one queue entry per outstanding burst (holds its ID).
  logic [ID_W-1:0] rd_q[$];
  logic [ID_W-1:0] wr_q[$];
  logic err_m = 1'b0;

  task automatic chk(input string tag, input string name,
                     input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $error("FAIL %s/%s observed=%0h expected=%0h", tag, name, obs, exp);
    end
  endtask

  // Driver: fresh random payloads; valids/readies/last set by the caller.
  task automatic rand_payload();
    i_axi_araddr = $urandom; i_axi_arid = 4'($urandom); i_axi_arlen = 8'($urandom);
    i_axi_aruser = 4'($urandom); i_axi_awaddr = $urandom; i_axi_awid = 4'($urandom);
    i_axi_awlen = 8'($urandom); i_axi_wdata = $urandom; i_axi_wstrb = 4'($urandom);
    o_axi_rid = 4'($urandom); o_axi_rdata = $urandom; o_axi_rresp = 2'($urandom);
    o_axi_bid = 4'($urandom); o_axi_bresp = 2'($urandom); o_axi_buser = 4'($urandom);
  endtask

  task automatic quiet();
    i_axi_arvalid = 0; i_axi_awvalid = 0; i_axi_wvalid = 0; i_axi_wlast = 0;
    o_axi_arready = 0; o_axi_awready = 0; o_axi_wready = 0;
    o_axi_rvalid = 0; o_axi_rlast = 0; i_axi_rready = 0;
    o_axi_bvalid = 0; i_axi_bready = 0;
  endtask

  // One clock: check combinational outputs against the model, clock, update
  // the model from the applied inputs, then check the registered status.
  task automatic step(input string tag);
    bit rd_full_m, wr_full_m, ar_hs, aw_hs, r_done, b_done;
    #1;
    rd_full_m = (rd_q.size() >= RD_OST);
    wr_full_m = (wr_q.size() >= WR_OST);
    chk(tag, "o_arvalid", o_axi_arvalid, i_axi_arvalid & ~rd_full_m);
    chk(tag, "i_arready", i_axi_arready, o_axi_arready & ~rd_full_m);
    chk(tag, "o_awvalid", o_axi_awvalid, i_axi_awvalid & ~wr_full_m);
    chk(tag, "i_awready", i_axi_awready, o_axi_awready & ~wr_full_m);
    chk(tag, "ar_pass", {o_axi_araddr, o_axi_arid, o_axi_arlen, o_axi_aruser},
        {i_axi_araddr, i_axi_arid, i_axi_arlen, i_axi_aruser});
    chk(tag, "w_pass", {o_axi_wdata, o_axi_wstrb, o_axi_wvalid, i_axi_wready, o_axi_awaddr},
        {i_axi_wdata, i_axi_wstrb, i_axi_wvalid, o_axi_wready, i_axi_awaddr});
    chk(tag, "rb_pass", {i_axi_rdata, i_axi_rid, i_axi_rvalid, i_axi_rlast, o_axi_rready,
        i_axi_bresp, i_axi_bid, i_axi_bvalid, o_axi_bready},
        {o_axi_rdata, o_axi_rid, o_axi_rvalid, o_axi_rlast, i_axi_rready,
        o_axi_bresp, o_axi_bid, o_axi_bvalid, i_axi_bready});
    ar_hs  = i_axi_arvalid && o_axi_arready && !rd_full_m;
    aw_hs  = i_axi_awvalid && o_axi_awready && !wr_full_m;
    r_done = o_axi_rvalid && i_axi_rready && o_axi_rlast;
    b_done = o_axi_bvalid && i_axi_bready;
    @(posedge clk);
    #1;
    if (rst) begin
      rd_q.delete(); wr_q.delete(); err_m = 1'b0;
    end else begin
      if (ar_hs) rd_q.push_back(i_axi_arid);
      if (r_done) begin
        if (rd_q.size() > 0) void'(rd_q.pop_front());
`ifdef E603_AXI_OST_ERR_EN
        else err_m = 1'b1;
`endif
      end
      if (aw_hs) wr_q.push_back(i_axi_awid);
      if (b_done) begin
        if (wr_q.size() > 0) void'(wr_q.pop_front());
`ifdef E603_AXI_OST_ERR_EN
        else err_m = 1'b1;
`endif
      end
    end
    chk(tag, "rd_ost_cnt", rd_ost_cnt, 8'(rd_q.size()));
    chk(tag, "wr_ost_cnt", wr_ost_cnt, 8'(wr_q.size()));
    chk(tag, "idle", idle, (rd_q.size() == 0 && wr_q.size() == 0));
    chk(tag, "ost_err", ost_err, err_m);
  endtask

  initial begin
    quiet();
    rand_payload();
    i_axi_arsize = 3'd2; i_axi_arburst = 2'd1; i_axi_arlock = 0; i_axi_arcache = 4'd0;
    i_axi_arprot = 3'd0; i_axi_arqos = 4'd0; i_axi_awsize = 3'd2; i_axi_awburst = 2'd1;
    i_axi_awlock = 0; i_axi_awcache = 4'd0; i_axi_awprot = 3'd0; i_axi_awqos = 4'd0;
    i_axi_awuser = 4'd0; i_axi_wuser = 4'd0; o_axi_ruser = 4'd0;

    // Reset state
    rst = 1;
    repeat (2) @(posedge clk);
    #1;
    rst = 0;
    chk("reset", "rd_ost_cnt", rd_ost_cnt, 8'd0);
    chk("reset", "wr_ost_cnt", wr_ost_cnt, 8'd0);
    chk("reset", "idle", idle, 1'b1);
    chk("reset", "ost_err", ost_err, 1'b0);

    // Three back-to-back ARs into RD_OST=2: third is stalled
    i_axi_arvalid = 1; o_axi_arready = 1;
    for (int i = 0; i < 3; i++) begin rand_payload(); step("ar_fill"); end
    chk("ar_fill", "third_stalled", i_axi_arready, 1'b0);
    chk("ar_fill", "cnt_is_2", rd_ost_cnt, 8'd2);

    // rlast frees a slot in N; AR blocked in N, accepted in N+1
    o_axi_rvalid = 1; i_axi_rready = 1; o_axi_rlast = 1;
    step("free_N");
    chk("free_N", "cnt_is_1", rd_ost_cnt, 8'd1);
    o_axi_rvalid = 0;
    step("reuse_N1");
    chk("reuse_N1", "cnt_is_2", rd_ost_cnt, 8'd2);

    // Down to 1, then simultaneous AR + rlast keeps it at 1
    i_axi_arvalid = 0; o_axi_rvalid = 1;
    step("drop_to_1");
    i_axi_arvalid = 1;
    step("ar_and_rlast");
    chk("ar_and_rlast", "cnt_is_1", rd_ost_cnt, 8'd1);

    // 4-beat read, rlast only on beat 4
    i_axi_arvalid = 0;
    for (int b = 0; b < 4; b++) begin
      o_axi_rlast = (b == 3);
      rand_payload();
      step("burst4");
    end
    chk("burst4", "cnt_is_0", rd_ost_cnt, 8'd0);
    quiet();

    // WR_OST=1: AW accepted, W beats pass while AW blocked, then B
    i_axi_awvalid = 1; o_axi_awready = 1;
    step("aw_accept");
    chk("aw_accept", "wr_is_1", wr_ost_cnt, 8'd1);
    i_axi_wvalid = 1; o_axi_wready = 1;
    for (int b = 0; b < 2; b++) begin rand_payload(); step("aw_blocked_w"); end
    chk("aw_blocked_w", "w_valid_pass", o_axi_wvalid, 1'b1);
    i_axi_awvalid = 0; i_axi_wvalid = 0; o_axi_bvalid = 1; i_axi_bready = 1;
    step("b_return");
    chk("b_return", "idle_back", idle, 1'b1);

    // B with wr count 0: underflow
    step("b_underflow");
    chk("b_underflow", "wr_stays_0", wr_ost_cnt, 8'd0);
    quiet();
    step("after_unf");

    // Reset mid-flight with rd=2, wr=1
    i_axi_arvalid = 1; o_axi_arready = 1; i_axi_awvalid = 1; o_axi_awready = 1;
    step("load"); step("load");
    chk("load", "rd_is_2", rd_ost_cnt, 8'd2);
    rst = 1;
    step("rst_pulse");
    rst = 0;
    chk("rst_pulse", "ost_err_clr", ost_err, 1'b0);
    chk("rst_pulse", "idle_set", idle, 1'b1);
    step("post_rst");

    // Randomized traffic
    for (int c = 0; c < 600; c++) begin
      rand_payload();
      i_axi_arvalid = 1'($urandom_range(0, 1)); o_axi_arready = 1'($urandom_range(0, 1));
      i_axi_awvalid = 1'($urandom_range(0, 1)); o_axi_awready = 1'($urandom_range(0, 1));
      i_axi_wvalid = 1'($urandom_range(0, 1)); o_axi_wready = 1'($urandom_range(0, 1));
      i_axi_wlast = 1'($urandom_range(0, 1));
      o_axi_rvalid = 1'($urandom_range(0, 1)); i_axi_rready = 1'($urandom_range(0, 1));
      o_axi_rlast = ($urandom_range(0, 2) == 0);
      o_axi_bvalid = ($urandom_range(0, 2) == 0); i_axi_bready = 1'($urandom_range(0, 1));
      rst = ($urandom_range(0, 99) == 0);
      step("random");
    end
    rst = 0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    if (miscompares == 0) $display("PASS");
    else $display("FAIL");
    $finish;
  end
endmodule

// File: doc/e603_subsys_axi_ost_limiter.md
E603_SUBSYS_AXI_OST_LIMITER -- requirements
Module: e603_subsys_axi_ost_limiter

Interface
REQ-001 Parameters SHALL be, one per line:
- AW, 32, address width
- DW, 32, data width
- ID_W, 4, ID width
- USR_W, 4, user width
- MW, 4, strobe width
- RD_OST, 4, max outstanding reads, range 1..255
- WR_OST, 4, max outstanding writes, range 1..255
REQ-002 Ports SHALL be, one per line (clock and reset first):
- clk  in  1  single clock
- rst  in  1  synchronous reset, active-high
- i_axi_ar*/aw*/w* payload  in  per AXI4 (as the async bridge i_ side)  upstream request payload
- i_axi_arvalid/awvalid/wvalid  in  1  upstream request valids
- i_axi_arready/awready/wready  out  1  upstream request readies
- o_axi_ar*/aw*/w* payload  out  per AXI4  request payload to the async bridge
- o_axi_arvalid/awvalid/wvalid  out  1  downstream request valids
- o_axi_arready/awready/wready  in  1  downstream request readies
- o_axi_r*/b* payload+valid  in  per AXI4  downstream responses
- o_axi_rready/bready  out  1  downstream response readies
- i_axi_r*/b* payload+valid  out  per AXI4  upstream responses
- i_axi_rready/bready  in  1  upstream response readies
- rd_ost_cnt  out  8  outstanding read bursts
- wr_ost_cnt  out  8  outstanding write bursts
- idle  out  1  both counts zero
- ost_err  out  1  sticky response-underflow error
REQ-003 The block SHALL use one clock, clk; reset rst SHALL be synchronous and active-high.

Function
REQ-004 All payload, W-channel, R-channel and B-channel signals SHALL pass through combinationally with zero latency; only AR and AW valid/ready SHALL be gated.
REQ-005 rd_full = (rd_ost_cnt == RD_OST); o_axi_arvalid = i_axi_arvalid & ~rd_full; i_axi_arready = o_axi_arready & ~rd_full.
REQ-006 wr_full = (wr_ost_cnt == WR_OST); the AW channel SHALL be gated identically using wr_full.
REQ-007 The gates SHALL depend only on registered counts: no combinational path from R/B handshakes to AR/AW valid/ready; a slot freed in cycle N is usable in cycle N+1.
REQ-008 The read count SHALL increment on an AR handshake (o_axi_arvalid & o_axi_arready) and decrement on a read-last handshake (i_axi_rvalid & i_axi_rready & i_axi_rlast).
REQ-009 The write count SHALL increment on an AW handshake and decrement on a B handshake (i_axi_bvalid & i_axi_bready).
REQ-010 Simultaneous increment and decrement on one counter SHALL leave it unchanged.
REQ-011 R beats without rlast SHALL NOT change the count.
REQ-012 A decrement at count 0 (underflow) SHALL hold the count at 0 and never wrap.
REQ-013 Counts SHALL never exceed RD_OST/WR_OST.
REQ-014 idle SHALL be registered-count-derived: (rd_ost_cnt == 0) & (wr_ost_cnt == 0).

Reset
REQ-015 While rst is high at a clk edge, rd_ost_cnt, wr_ost_cnt and ost_err SHALL clear to 0, and idle SHALL read 1 the following cycle.
REQ-016 A reset asserted mid-burst SHALL discard all tracking; responses arriving after reset SHALL be treated as underflow per REQ-012/REQ-018.
REQ-017 Pass-through outputs SHALL carry no reset; gated readies/valids SHALL reflect the reset counts (ungated).

Configuration
REQ-018 With E603_AXI_OST_ERR_EN defined, ost_err SHALL set one cycle after any underflow decrement (read or write) and stay set until rst.
REQ-019 Without E603_AXI_OST_ERR_EN, ost_err SHALL be tied to 0, no error register SHALL exist, and underflow SHALL saturate silently.

Verification
REQ-020 RD_OST=2, three back-to-back ARs with o_axi_arready=1 -> two accepted, third stalled (i_axi_arready=0, o_axi_arvalid=0), rd_ost_cnt=2.
REQ-021 Count=2 full, rlast handshake in cycle N -> AR still blocked in N, accepted in N+1, rd_ost_cnt returns to 2.
REQ-022 rd_ost_cnt=1, AR handshake and rlast handshake in the same cycle -> rd_ost_cnt stays 1; 4-beat read with rlast only on beat 4 -> count drops only after beat 4.
REQ-023 WR_OST=1, AW accepted, B returned -> wr_ost_cnt goes 1 then 0, idle returns to 1; W beats pass through while AW is blocked.
REQ-024 B handshake with wr_ost_cnt=0 -> count stays 0; ost_err=1 next cycle with E603_AXI_OST_ERR_EN, 0 without it.
REQ-025 rst pulse with rd_ost_cnt=2 and wr_ost_cnt=1 -> both 0 and idle=1 next cycle, ost_err=0, AR/AW ungated.
